// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the serial adder/subtractor.
// Sizing functions derive the digit-step count and counter width.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    function automatic int num_steps(input int w, input int d);
        return w / d;
    endfunction

    function automatic int cnt_width(input int w, input int d);
        int n;
        n = w / d;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_ok(input int w, input int d);
        return (w >= 2) && (d >= 1) && (d <= w) && ((w % d) == 0);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple slice of the serial adder.
// c_msb is the carry into the slice's top bit, used for overflow.
module digit_adder #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    always_comb begin
        c     = '0;
        sum   = '0;
        c[0]  = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout  = c[DIGIT];
        c_msb = c[DIGIT-1];
    end

endmodule

// File: rtl/serial_adder_subtractor.sv
// Multi-cycle two's-complement adder/subtractor, DIGIT bits per clock.
// Results build in a shadow register and publish on the final step.
module serial_adder_subtractor
    import addsub_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] answer,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = num_steps(WIDTH, DIGIT);
    localparam int CW = cnt_width(WIDTH, DIGIT);

    if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
        $error("serial_adder_subtractor: bad WIDTH/DIGIT");
    end

    state_t           state_q;
    state_t           state_d;
    logic             load;
    logic             step;
    logic             last;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    int               idx;
    logic [DIGIT-1:0] da;
    logic [DIGIT-1:0] db;
    logic [DIGIT-1:0] dsum;
    logic             dcout;
    logic             dmsb;

    assign last = (cnt == CW'(N - 1));
    assign busy = (state_q == RUN);
    assign done = (state_q == FIN);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Current digit of each operand, and the result with it merged in.
    always_comb begin
        idx      = int'(cnt) * DIGIT;
        da       = opa[idx +: DIGIT];
        db       = opb[idx +: DIGIT];
        res_next = shadow;
        res_next[idx +: DIGIT] = dsum;
    end

    digit_adder #(
        .DIGIT(DIGIT)
    ) u_slice (
        .a    (da),
        .b    (db),
        .cin  (carry),
        .sum  (dsum),
        .cout (dcout),
        .c_msb(dmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt     <= '0;
            opa     <= '0;
            opb     <= '0;
            carry   <= 1'b0;
            shadow  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                opa   <= a;
                opb   <= s ? ~b : b;
                carry <= s;
                cnt   <= '0;
            end else if (step) begin
                shadow <= res_next;
                carry  <= dcout;
                cnt    <= last ? '0 : cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            answer <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b1;
        end else if (step && last) begin
            answer <= res_next;
            cout   <= dcout;
            ovf    <= dcout ^ dmsb;
            zero   <= (res_next == '0);
        end
    end

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Randomized and directed bench for serial_adder_subtractor.
// Three configurations run side by side against one arithmetic model.
module tb_serial_adder_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ta  [3];
    logic [7:0] tbv [3];
    logic       ts  [3];
    logic       tst [3];
    logic       bsy [3];
    logic       dn  [3];
    logic       co  [3];
    logic       ov  [3];
    logic       zr  [3];
    logic [5:0] ans0;
    logic [7:0] ans1;
    logic [7:0] ans2;

    int          vecs = 0;
    int          errs = 0;
    int          rem  [3];
    logic        mdone[3];
    logic [10:0] pend [3];
    logic [10:0] outv [3];

    always #5 clk = ~clk;

    serial_adder_subtractor #(.WIDTH(6), .DIGIT(2)) u0 (
        .clk(clk), .rst_n(rst_n), .a(ta[0][5:0]), .b(tbv[0][5:0]),
        .s(ts[0]), .start(tst[0]), .busy(bsy[0]), .done(dn[0]),
        .answer(ans0), .cout(co[0]), .ovf(ov[0]), .zero(zr[0])
    );

    serial_adder_subtractor #(.WIDTH(8), .DIGIT(8)) u1 (
        .clk(clk), .rst_n(rst_n), .a(ta[1]), .b(tbv[1]),
        .s(ts[1]), .start(tst[1]), .busy(bsy[1]), .done(dn[1]),
        .answer(ans1), .cout(co[1]), .ovf(ov[1]), .zero(zr[1])
    );

    serial_adder_subtractor #(.WIDTH(8), .DIGIT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .a(ta[2]), .b(tbv[2]),
        .s(ts[2]), .start(tst[2]), .busy(bsy[2]), .done(dn[2]),
        .answer(ans2), .cout(co[2]), .ovf(ov[2]), .zero(zr[2])
    );

    function automatic int nsteps(input int i);
        return (i == 0) ? 3 : (i == 1) ? 1 : 8;
    endfunction

    function automatic int wid(input int i);
        return (i == 0) ? 6 : 8;
    endfunction

    // Reference result {cout, ovf, zero, answer[7:0]} from plain arithmetic.
    function automatic logic [10:0] ref_op(input int av, input int bv,
                                           input int sv, input int w);
        int mask, ua, ub, sa, sb, r, hi, lo;
        logic c, o, z;
        logic [7:0] an;
        mask = (1 << w) - 1;
        ua   = av & mask;
        ub   = bv & mask;
        an   = 8'((sv != 0 ? ua - ub : ua + ub) & mask);
        c    = (sv != 0) ? (ua >= ub) : (ua + ub > mask);
        sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        r    = (sv != 0) ? sa - sb : sa + sb;
        hi   = (1 << (w - 1)) - 1;
        lo   = -(1 << (w - 1));
        o    = (r > hi) || (r < lo);
        z    = (an == 8'd0);
        return {c, o, z, an};
    endfunction

    // Model: an accepted request completes nsteps edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                rem[i]   <= 0;
                mdone[i] <= 1'b0;
                outv[i]  <= 11'h100;
                pend[i]  <= 11'h100;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                mdone[i] <= 1'b0;
                if (rem[i] > 0) begin
                    rem[i] <= rem[i] - 1;
                    if (rem[i] == 1) begin
                        outv[i]  <= pend[i];
                        mdone[i] <= 1'b1;
                    end
                end else if (tst[i]) begin
                    rem[i]  <= nsteps(i);
                    pend[i] <= ref_op(int'(ta[i]), int'(tbv[i]),
                                      int'(ts[i]), wid(i));
                end
            end
        end
    end

    function automatic logic [7:0] get_ans(input int i);
        return (i == 0) ? {2'b00, ans0} : (i == 1) ? ans1 : ans2;
    endfunction

    function automatic logic [10:0] get_res(input int i);
        return {co[i], ov[i], zr[i], get_ans(i)};
    endfunction

    task automatic tick();
        logic [12:0] act;
        logic [12:0] exp;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            act = {bsy[i], dn[i], get_res(i)};
            exp = {rem[i] > 0, mdone[i], outv[i]};
            vecs++;
            if (act !== exp) begin
                errs++;
                $display("FAIL cycle inst%0d t=%0t got %b want %b",
                         i, $time, act, exp);
            end
        end
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input int i, input int av, input int bv,
                          input int sv, output int cyc, output int bcnt);
        ta[i]  = 8'(av);
        tbv[i] = 8'(bv);
        ts[i]  = sv[0];
        tst[i] = 1'b1;
        tick();
        tst[i] = 1'b0;
        cyc  = 1;
        bcnt = int'(bsy[i]);
        while (!dn[i] && cyc < 30) begin
            tick();
            cyc++;
            bcnt += int'(bsy[i]);
        end
        if (cyc >= 30) lit("timeout", cyc, nsteps(i) + 1);
    endtask

    int          dav [5] = '{15, 15, 33, 31, 63};
    int          dbv [5] = '{33, 33, 33, 1, 1};
    int          dsv [5] = '{0, 1, 1, 0, 0};
    logic [10:0] dex [5] = '{11'b000_00110000, 11'b010_00101110,
                             11'b101_00000000, 11'b010_00100000,
                             11'b101_00000000};

    initial begin
        int cyc, bcnt, pulses;
        logic [10:0] e;
        for (int i = 0; i < 3; i++) begin
            ta[i] = 8'd0; tbv[i] = 8'd0; ts[i] = 1'b0; tst[i] = 1'b0;
        end
        repeat (3) tick();
        for (int i = 0; i < 3; i++)
            lit("reset_state", int'({bsy[i], dn[i], get_res(i)}), 13'h100);
        #2 rst_n = 1'b1;
        tick();

        // Hand-computed 6-bit cases pin both the model and the DUT.
        for (int k = 0; k < 5; k++) begin
            lit("model_lit", int'(ref_op(dav[k], dbv[k], dsv[k], 6)),
                int'(dex[k]));
            run_op(0, dav[k], dbv[k], dsv[k], cyc, bcnt);
            lit("latency_w6", cyc, 4);
            lit("busy_cycles_w6", bcnt, 3);
            lit("result_w6", int'(get_res(0)), int'(dex[k]));
            tick();
        end

        // Same operands on the N=1 and N=8 configurations.
        for (int i = 1; i < 3; i++) begin
            for (int k = 0; k < 5; k++) begin
                run_op(i, dav[k], dbv[k], dsv[k], cyc, bcnt);
                lit("latency_w8", cyc, nsteps(i) + 1);
                e = ref_op(dav[k], dbv[k], dsv[k], 8);
                lit("result_w8", int'(get_res(i)), int'(e));
            end
            lit("model_w8_sub", int'(ref_op(200, 100, 1, 8)),
                int'(11'b110_01100100));
        end

        // Start held high: accepts at edges 0,4,8, done after 3,7,11.
        ta[0] = 8'd10; tbv[0] = 8'd5; ts[0] = 1'b0; tst[0] = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            pulses += int'(dn[0]);
        end
        tst[0] = 1'b0;
        lit("held_start_pulses", pulses, 3);
        repeat (3) tick();

        // A start pulse during RUN must not disturb the running operation.
        ta[0] = 8'd20; tbv[0] = 8'd7; ts[0] = 1'b0; tst[0] = 1'b1;
        tick();
        tst[0] = 1'b0;
        tick();
        ta[0] = 8'd1; tbv[0] = 8'd1; tst[0] = 1'b1;
        tick();
        tst[0] = 1'b0;
        cyc = 0;
        while (!dn[0] && cyc < 30) begin
            tick();
            cyc++;
        end
        lit("start_in_run_ignored", int'(get_res(0)), 11'b000_00011011);
        repeat (3) tick();

        // Asynchronous reset while RUN is at count 1.
        ta[0] = 8'd9; tbv[0] = 8'd9; ts[0] = 1'b0; tst[0] = 1'b1;
        tick();
        tst[0] = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            lit("mid_run_reset", int'({bsy[i], dn[i], get_res(i)}), 13'h100);
        repeat (2) tick();
        #2 rst_n = 1'b1;
        repeat (5) tick();
        run_op(0, 9, 9, 0, cyc, bcnt);
        lit("after_reset_op", int'(get_res(0)), 11'b000_00010010);
        tick();

        // Random traffic on all three configurations at once.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 3; i++) begin
                tst[i] = ($urandom_range(0, 3) == 0);
                ta[i]  = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
                tbv[i] = ($urandom_range(0, 4) == 0) ? 8'h01 : 8'($urandom);
                ts[i]  = 1'($urandom_range(0, 1));
            end
            tick();
        end
        for (int i = 0; i < 3; i++) tst[i] = 1'b0;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
